// File: rtl/fb_pkg.sv
// fb_pkg: shared defaults and access tags for the framebuffer arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fb_pkg;

  localparam int AW_DEF       = 19;  // framebuffer address width
  localparam int DW_DEF       = 8;   // pixel width
  localparam int WAIT_MAX_DEF = 8;   // reader starvation limit in cycles
  localparam int WCW          = 8;   // wait counter width, covers WAIT_MAX up to 255

  // Tag carried down the read-return pipeline alongside each memory access.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_WR   = 2'd1,
    TAG_RD0  = 2'd2,
    TAG_RD1  = 2'd3
  } tag_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: requester-side and framebuffer-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req/gnt handshake; a requester holds req/addr/data until gnt.
// Ports: slave = arbiter view, master = requester + memory view.
interface fb_arbiter_if
  import fb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          rd0_req;
  logic          rd1_req;
  logic [AW-1:0] rd0_addr;
  logic [AW-1:0] rd1_addr;
  logic          rd0_gnt;
  logic          rd1_gnt;
  logic          rd0_valid;
  logic          rd1_valid;
  logic [DW-1:0] rd_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd0_req, rd1_req, rd0_addr, rd1_addr, mem_dout,
    output wr_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, rd_data,
           mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd0_req, rd1_req, rd0_addr, rd1_addr, mem_dout,
    input  wr_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, rd_data,
           mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/fb_wait_cnt.sv
// fb_wait_cnt: saturating count of cycles a reader has waited with req high and no gnt.
// Latency: starved is combinational from the registered count and the live req.
// Backpressure: none; counts whatever the req/gnt pair shows each cycle.
// Ports: pclk, rst_n (sync, active-low), req, gnt in; starved out.
module fb_wait_cnt
  import fb_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic starved
);

  logic [WCW-1:0] cnt;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!req || gnt) begin
      cnt <= '0;
    end else if (cnt != WCW'(WAIT_MAX)) begin
      cnt <= cnt + WCW'(1);
    end
  end

  // A request dropped this cycle must not win on a stale saturated count.
  assign starved = req && (cnt == WCW'(WAIT_MAX));

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer arbiter, one writer and two readers (rd0 display, rd1 CNN).
// Latency: gnt combinational; mem_* registered at N+1; rdN_valid/rd_data at N+2.
// Backpressure: losers keep req high; a starved reader beats the writer.
// Ports: pclk, rst_n (sync, active-low), bus (fb_arbiter_if.slave).
// Option: define FB_ARB_RR_EN for round-robin between readers, else rd0 has fixed priority.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input logic         pclk,
  input logic         rst_n,
  fb_arbiter_if.slave bus
);

  logic          starved0;
  logic          starved1;
  logic          pick_rd1;   // reader choice when both readers contend at equal rank
  tag_t          gnt_tag;
  tag_t          tag_s1;
  tag_t          tag_s2;
  logic          rd_now;
  logic [DW-1:0] rd_data_q;

  fb_wait_cnt #(.WAIT_MAX(WAIT_MAX)) u_wait0 (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .req     (bus.rd0_req),
    .gnt     (bus.rd0_gnt),
    .starved (starved0)
  );

  fb_wait_cnt #(.WAIT_MAX(WAIT_MAX)) u_wait1 (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .req     (bus.rd1_req),
    .gnt     (bus.rd1_gnt),
    .starved (starved1)
  );

`ifdef FB_ARB_RR_EN
  // 0: rd0 preferred next, 1: rd1 preferred next. Points away from the last reader served.
  logic rr_ptr;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (gnt_tag == TAG_RD0) begin
      rr_ptr <= 1'b1;
    end else if (gnt_tag == TAG_RD1) begin
      rr_ptr <= 1'b0;
    end
  end

  assign pick_rd1 = rr_ptr;
`else
  assign pick_rd1 = 1'b0;
`endif

  // Starved reader > writer > non-starved readers.
  always_comb begin
    gnt_tag = TAG_NONE;
    if (!rst_n) begin
      gnt_tag = TAG_NONE;
    end else if (starved0 && starved1) begin
      gnt_tag = pick_rd1 ? TAG_RD1 : TAG_RD0;
    end else if (starved0) begin
      gnt_tag = TAG_RD0;
    end else if (starved1) begin
      gnt_tag = TAG_RD1;
    end else if (bus.wr_req) begin
      gnt_tag = TAG_WR;
    end else if (bus.rd0_req && bus.rd1_req) begin
      gnt_tag = pick_rd1 ? TAG_RD1 : TAG_RD0;
    end else if (bus.rd0_req) begin
      gnt_tag = TAG_RD0;
    end else if (bus.rd1_req) begin
      gnt_tag = TAG_RD1;
    end
  end

  assign bus.wr_gnt  = (gnt_tag == TAG_WR);
  assign bus.rd0_gnt = (gnt_tag == TAG_RD0);
  assign bus.rd1_gnt = (gnt_tag == TAG_RD1);

  // Memory command stage (N+1) and the tag pipeline that tracks reads to N+2.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      tag_s1       <= TAG_NONE;
      tag_s2       <= TAG_NONE;
      rd_data_q    <= '0;
    end else begin
      bus.mem_en <= (gnt_tag != TAG_NONE);
      bus.mem_we <= (gnt_tag == TAG_WR);
      case (gnt_tag)
        TAG_WR: begin
          bus.mem_addr <= bus.wr_addr;
          bus.mem_din  <= bus.wr_data;
        end
        TAG_RD0: bus.mem_addr <= bus.rd0_addr;
        TAG_RD1: bus.mem_addr <= bus.rd1_addr;
        default: ;
      endcase
      tag_s1 <= gnt_tag;
      tag_s2 <= tag_s1;
      if (rd_now) begin
        rd_data_q <= bus.mem_dout;
      end
    end
  end

  // mem_dout is live during the return cycle; the shadow register keeps it afterwards.
  assign rd_now        = (tag_s2 == TAG_RD0) || (tag_s2 == TAG_RD1);
  assign bus.rd_data   = rd_now ? bus.mem_dout : rd_data_q;
  assign bus.rd0_valid = (tag_s2 == TAG_RD0);
  assign bus.rd1_valid = (tag_s2 == TAG_RD1);

endmodule
